// File: rtl/accel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : accel_pkg                                                       |
// | Purpose  : Shared constants and helpers for the accelerator operand bank.  |
// |            Word width of the SW port, words-per-slot helper and the bit    |
// |            positions of the STATUS register.                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package accel_pkg;

  localparam int WORD_W          = 32;
  localparam int STATUS_FULL_LSB = 0;
  localparam int STATUS_ERR_BIT  = 31;

  // Number of 32-bit SW words that make up one operand slot.
  function automatic int words_per_slot(input int data_width);
    return data_width / WORD_W;
  endfunction

  // STATUS bit that reports the result flag of a given slot.
  function automatic int status_result_bit(input int num_slots, input int slot);
    return num_slots + slot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : operand_slot                                                    |
// | Purpose  : One operand slot: word memory, per-word fill mask, full and     |
// |            result flags. SW fills it word by word, HW overwrites it in     |
// |            one wide beat.                                                  |
// | Ports    : clk/resetn            clock, sync active-low reset              |
// |            sw_we/sw_word/sw_wdata  SW word write                           |
// |            rd_word/rd_word_data  SW word read port (combinational)         |
// |            hw_we/hw_wdata        HW wide result write (has priority)       |
// |            consume               HW accepted the full operand              |
// |            result_clr            W1C of the result flag                    |
// |            data/full/result      slot contents and flags                   |
// |            sw_drop               SW write was discarded (feeds err)        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module operand_slot
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH = 1024,
  parameter int WORD_IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sw_we,
  input  logic [WORD_IDX_W-1:0] sw_word,
  input  logic [WORD_W-1:0]     sw_wdata,
  input  logic [WORD_IDX_W-1:0] rd_word,
  output logic [WORD_W-1:0]     rd_word_data,
  input  logic                  hw_we,
  input  logic [DATA_WIDTH-1:0] hw_wdata,
  input  logic                  consume,
  input  logic                  result_clr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  full,
  output logic                  result,
  output logic                  sw_drop
);

  localparam int c_WORDS = words_per_slot(DATA_WIDTH);

  logic [WORD_W-1:0]  r_mem [c_WORDS];
  logic [c_WORDS-1:0] r_mask;
  logic               r_full;
  logic               r_result;

  logic               w_sw_accept;
  logic [c_WORDS-1:0] w_mask_set;

  // A SW word is lost when the slot is waiting for HW or when HW overwrites
  // the same slot in this cycle.
  assign w_sw_accept = sw_we && !r_full && !hw_we;
  assign sw_drop     = sw_we && !w_sw_accept;
  assign w_mask_set  = r_mask | (c_WORDS'(1) << sw_word);

  // Memory is deliberately not reset: flags alone define validity.
  always_ff @(posedge clk) begin
    if (hw_we) begin
      for (int i = 0; i < c_WORDS; i++) begin
        r_mem[i] <= hw_wdata[i*WORD_W +: WORD_W];
      end
    end else if (w_sw_accept) begin
      r_mem[sw_word] <= sw_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mask   <= '0;
      r_full   <= 1'b0;
      r_result <= 1'b0;
    end else begin
      if (hw_we) begin
        r_mask <= '0;
      end else if (w_sw_accept) begin
        // Rewriting an already-set word leaves the mask unchanged, so only
        // distinct words advance the slot towards full.
        if (&w_mask_set) begin
          r_mask <= '0;
          r_full <= 1'b1;
        end else begin
          r_mask <= w_mask_set;
        end
      end
      // consume requires full=1 while completion requires full=0: exclusive.
      if (consume) begin
        r_full <= 1'b0;
      end
      // A new result beats a simultaneous W1C.
      if (hw_we) begin
        r_result <= 1'b1;
      end else if (result_clr) begin
        r_result <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < c_WORDS; i++) begin : g_pack
    assign data[i*WORD_W +: WORD_W] = r_mem[i];
  end

  assign rd_word_data = r_mem[rd_word];
  assign full         = r_full;
  assign result       = r_result;

endmodule
`default_nettype wire

// File: rtl/operand_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : operand_bank                                                    |
// | Purpose  : Multi-slot SW<->HW operand buffer. SW fills slots 32 bits at a  |
// |            time, HW consumes full slots via valid/ready and returns        |
// |            results in one wide beat. STATUS register reports full/result   |
// |            flags and a sticky error for dropped SW writes.                 |
// | Ports    : clk/resetn                       clock, sync active-low reset   |
// |            sw_addr/sw_wdata/sw_we/sw_re     SW bus (byte address)          |
// |            sw_rdata/sw_rvalid               registered read response       |
// |            hw_rd_slot/valid/ready/data      HW operand consume port        |
// |            hw_wr_slot/valid/ready/data      HW result write port           |
// |            hw_wr_done                       pulse after accepted result    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module operand_bank
  import accel_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH      = 1024,
  parameter int NUM_SLOTS       = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [BRAM_ADDR_WIDTH-1:0]   sw_addr,
  input  logic [31:0]                  sw_wdata,
  input  logic                         sw_we,
  input  logic                         sw_re,
  output logic [31:0]                  sw_rdata,
  output logic                         sw_rvalid,
  input  logic [$clog2(NUM_SLOTS)-1:0] hw_rd_slot,
  output logic                         hw_rd_valid,
  input  logic                         hw_rd_ready,
  output logic [DATA_WIDTH-1:0]        hw_rd_data,
  input  logic [$clog2(NUM_SLOTS)-1:0] hw_wr_slot,
  input  logic                         hw_wr_valid,
  output logic                         hw_wr_ready,
  input  logic [DATA_WIDTH-1:0]        hw_wr_data,
  output logic                         hw_wr_done
);

  localparam int c_WORDS       = words_per_slot(DATA_WIDTH);
  localparam int c_SLOT_W      = $clog2(NUM_SLOTS);
  localparam int c_WORD_IDX_W  = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
  localparam int c_STATUS_WIDX = NUM_SLOTS * c_WORDS;
  localparam int c_RESULT_LSB  = status_result_bit(NUM_SLOTS, 0);

  // Address decode, done in 32-bit arithmetic so W need not be a power of 2.
  logic [31:0]             w_widx;
  logic [31:0]             w_slot_full;
  logic [31:0]             w_word_full;
  logic [c_SLOT_W-1:0]     w_slot;
  logic [c_WORD_IDX_W-1:0] w_word;
  logic                    w_in_data;
  logic                    w_is_status;
  logic                    w_status_we;
  logic                    w_unused_addr;

  assign w_widx        = 32'(sw_addr[BRAM_ADDR_WIDTH-1:2]);
  assign w_slot_full   = w_widx / c_WORDS;
  assign w_word_full   = w_widx % c_WORDS;
  assign w_slot        = w_slot_full[c_SLOT_W-1:0];
  assign w_word        = w_word_full[c_WORD_IDX_W-1:0];
  assign w_in_data     = w_widx < 32'(c_STATUS_WIDX);
  assign w_is_status   = w_widx == 32'(c_STATUS_WIDX);
  assign w_status_we   = sw_we && w_is_status;
  assign w_unused_addr = ^{sw_addr[1:0], w_slot_full[31:c_SLOT_W],
                           w_word_full[31:c_WORD_IDX_W]};

  logic [NUM_SLOTS-1:0]  w_full;
  logic [NUM_SLOTS-1:0]  w_result;
  logic [NUM_SLOTS-1:0]  w_drop;
  logic [DATA_WIDTH-1:0] w_data    [NUM_SLOTS];
  logic [WORD_W-1:0]     w_rd_word [NUM_SLOTS];
  logic                  w_hw_accept;

  assign w_hw_accept = hw_wr_valid && hw_wr_ready;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    operand_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORD_IDX_W (c_WORD_IDX_W)
    ) u_slot (
      .clk          (clk),
      .resetn       (resetn),
      .sw_we        (sw_we && w_in_data && (w_slot == c_SLOT_W'(s))),
      .sw_word      (w_word),
      .sw_wdata     (sw_wdata),
      .rd_word      (w_word),
      .rd_word_data (w_rd_word[s]),
      .hw_we        (w_hw_accept && (hw_wr_slot == c_SLOT_W'(s))),
      .hw_wdata     (hw_wr_data),
      .consume      (hw_rd_valid && hw_rd_ready && (hw_rd_slot == c_SLOT_W'(s))),
      .result_clr   (w_status_we && sw_wdata[c_RESULT_LSB + s]),
      .data         (w_data[s]),
      .full         (w_full[s]),
      .result       (w_result[s]),
      .sw_drop      (w_drop[s])
    );
  end

  // HW-facing slot selection.
  always_comb begin
    hw_rd_valid = 1'b0;
    hw_rd_data  = '0;
    hw_wr_ready = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (hw_rd_slot == c_SLOT_W'(s)) begin
        hw_rd_valid = w_full[s];
        hw_rd_data  = w_data[s];
      end
      if (hw_wr_slot == c_SLOT_W'(s)) begin
        hw_wr_ready = !w_full[s];
      end
    end
  end

  logic        r_err;
  logic [31:0] w_status;
  logic [31:0] w_rd_value;

  always_comb begin
    w_status = '0;
    w_status[STATUS_FULL_LSB +: NUM_SLOTS] = w_full;
    w_status[c_RESULT_LSB +: NUM_SLOTS]    = w_result;
    w_status[STATUS_ERR_BIT]               = r_err;
  end

  always_comb begin
    w_rd_value = '0;
    if (w_is_status) begin
      w_rd_value = w_status;
    end else if (w_in_data) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (w_slot == c_SLOT_W'(s)) begin
          w_rd_value = w_rd_word[s];
        end
      end
    end
  end

  // A drop in the same cycle as the W1C keeps err set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_err && !(w_status_we && sw_wdata[STATUS_ERR_BIT])) || (|w_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sw_rdata   <= '0;
      sw_rvalid  <= 1'b0;
      hw_wr_done <= 1'b0;
    end else begin
      sw_rvalid  <= sw_re;
      hw_wr_done <= w_hw_accept;
      if (sw_re) begin
        sw_rdata <= w_rd_value;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_operand_bank                                                 |
// | Purpose  : Self-checking bench for operand_bank with a behavioural model,  |
// |            directed scenarios and a randomized phase.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_operand_bank;

  localparam int AW = 10;
  localparam int DW = 1024;
  localparam int NS = 4;
  localparam int W  = DW / 32;
  localparam logic [AW-1:0] STATUS_ADDR = 10'h200;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] sw_addr;
  logic [31:0]   sw_wdata;
  logic          sw_we;
  logic          sw_re;
  logic [31:0]   sw_rdata;
  logic          sw_rvalid;
  logic [1:0]    hw_rd_slot;
  logic          hw_rd_valid;
  logic          hw_rd_ready;
  logic [DW-1:0] hw_rd_data;
  logic [1:0]    hw_wr_slot;
  logic          hw_wr_valid;
  logic          hw_wr_ready;
  logic [DW-1:0] hw_wr_data;
  logic          hw_wr_done;

  always #5 clk = ~clk;

  operand_bank #(.BRAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLOTS(NS)) dut (
    .clk(clk), .resetn(resetn),
    .sw_addr(sw_addr), .sw_wdata(sw_wdata), .sw_we(sw_we), .sw_re(sw_re),
    .sw_rdata(sw_rdata), .sw_rvalid(sw_rvalid),
    .hw_rd_slot(hw_rd_slot), .hw_rd_valid(hw_rd_valid), .hw_rd_ready(hw_rd_ready),
    .hw_rd_data(hw_rd_data),
    .hw_wr_slot(hw_wr_slot), .hw_wr_valid(hw_wr_valid), .hw_wr_ready(hw_wr_ready),
    .hw_wr_data(hw_wr_data), .hw_wr_done(hw_wr_done)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Behavioural model state.
  logic [31:0] m_mem   [NS][W];
  bit          m_known [NS][W];
  bit          m_mask  [NS][W];
  bit          m_full  [NS];
  bit          m_result[NS];
  bit          m_err;
  logic [31:0] m_rdata;
  bit          m_rknown;
  bit          m_rvalid;
  bit          m_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    int bad;
    bad = -1;
    vectors++;
    for (int i = W - 1; i >= 0; i--) begin
      if (got[i*32 +: 32] !== exp[i*32 +: 32]) bad = i;
    end
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s word %0d: got %h expected %h", name, bad,
               got[bad*32 +: 32], exp[bad*32 +: 32]);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] v;
    v = '0;
    for (int s = 0; s < NS; s++) begin
      v[s]      = m_full[s];
      v[NS + s] = m_result[s];
    end
    v[31] = m_err;
    return v;
  endfunction

  function automatic logic [DW-1:0] m_slot_vec(input int s);
    logic [DW-1:0] v;
    for (int i = 0; i < W; i++) v[i*32 +: 32] = m_mem[s][i];
    return v;
  endfunction

  // Model: applies the rules to the state as it was before the edge.
  always @(posedge clk) begin
    int widx, ms, mw, hs, cs;
    bit acc, cons, all;
    if (!resetn) begin
      for (int s = 0; s < NS; s++) begin
        m_full[s]   = 1'b0;
        m_result[s] = 1'b0;
        for (int i = 0; i < W; i++) m_mask[s][i] = 1'b0;
      end
      m_err    = 1'b0;
      m_rdata  = '0;
      m_rknown = 1'b1;
      m_rvalid = 1'b0;
      m_done   = 1'b0;
    end else begin
      widx = int'(sw_addr) / 4;
      ms   = widx / W;
      mw   = widx % W;
      hs   = int'(hw_wr_slot);
      cs   = int'(hw_rd_slot);
      if (sw_re) begin
        if (widx == NS * W) begin
          m_rdata = m_status(); m_rknown = 1'b1;
        end else if (widx < NS * W) begin
          m_rdata = m_mem[ms][mw]; m_rknown = m_known[ms][mw];
        end else begin
          m_rdata = '0; m_rknown = 1'b1;
        end
      end
      m_rvalid = sw_re;
      acc  = hw_wr_valid && !m_full[hs];
      cons = hw_rd_ready && m_full[cs];
      if (sw_we && widx == NS * W) begin
        for (int s = 0; s < NS; s++) if (sw_wdata[NS + s]) m_result[s] = 1'b0;
        if (sw_wdata[31]) m_err = 1'b0;
      end
      if (sw_we && widx < NS * W) begin
        if (m_full[ms] || (acc && hs == ms)) begin
          m_err = 1'b1;
        end else begin
          m_mem[ms][mw]   = sw_wdata;
          m_known[ms][mw] = 1'b1;
          m_mask[ms][mw]  = 1'b1;
          all = 1'b1;
          for (int i = 0; i < W; i++) all = all && m_mask[ms][i];
          if (all) begin
            m_full[ms] = 1'b1;
            for (int i = 0; i < W; i++) m_mask[ms][i] = 1'b0;
          end
        end
      end
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          m_mem[hs][i]   = hw_wr_data[i*32 +: 32];
          m_known[hs][i] = 1'b1;
          m_mask[hs][i]  = 1'b0;
        end
        m_result[hs] = 1'b1;
      end
      if (cons) m_full[cs] = 1'b0;
      m_done = acc;
    end
  end

  // Compare process.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sw_rvalid", {31'b0, sw_rvalid}, {31'b0, m_rvalid});
      if (m_rknown) check("sw_rdata", sw_rdata, m_rdata);
      check("hw_wr_done", {31'b0, hw_wr_done}, {31'b0, m_done});
      check("hw_rd_valid", {31'b0, hw_rd_valid}, {31'b0, m_full[hw_rd_slot]});
      check("hw_wr_ready", {31'b0, hw_wr_ready}, {31'b0, !m_full[hw_wr_slot]});
      if (m_full[hw_rd_slot]) check_wide("hw_rd_data", hw_rd_data, m_slot_vec(int'(hw_rd_slot)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw_write(input logic [AW-1:0] a, input logic [31:0] d);
    sw_addr = a; sw_wdata = d; sw_we = 1'b1;
    tick();
    sw_we = 1'b0;
  endtask

  task automatic sw_read_lit(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    sw_addr = a; sw_re = 1'b1;
    tick();
    sw_re = 1'b0;
    check(name, sw_rdata, exp);
  endtask

  task automatic hw_result(input logic [1:0] s, input logic [DW-1:0] d);
    hw_wr_slot = s; hw_wr_data = d; hw_wr_valid = 1'b1;
    tick();
    hw_wr_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; sw_addr = '0; sw_wdata = '0; sw_we = 1'b0; sw_re = 1'b0;
    hw_rd_slot = '0; hw_rd_ready = 1'b0; hw_wr_slot = '0; hw_wr_valid = 1'b0;
    hw_wr_data = '0;
    tick(); tick();
    chk_en = 1'b1;
    check("reset sw_rdata", sw_rdata, 32'h0);
    check("reset sw_rvalid", {31'b0, sw_rvalid}, 32'h0);
    check("reset hw_wr_done", {31'b0, hw_wr_done}, 32'h0);
    resetn = 1'b1;
    sw_read_lit("status after reset", STATUS_ADDR, 32'h0);

    // Slot 0 in order.
    hw_rd_slot = 2'd0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) check("slot0 not full early", {31'b0, hw_rd_valid}, 32'h0);
      sw_write(AW'(i * 4), 32'h1000_0000 + 32'(i));
    end
    check("slot0 full", {31'b0, hw_rd_valid}, 32'h1);
    check("slot0 word0", hw_rd_data[31:0], 32'h1000_0000);

    // Slot 1 in reverse, with a rewrite of word 0 mid-fill.
    hw_rd_slot = 2'd1;
    sw_write(10'h080, 32'h2000_00AA);
    for (int k = W - 1; k >= 1; k--) begin
      if (k == 16) sw_write(10'h080, 32'h2000_0000);
      if (k == 1) check("slot1 not full early", {31'b0, hw_rd_valid}, 32'h0);
      sw_write(AW'(32'h80 + k * 4), 32'h2000_0000 + 32'(k));
    end
    check("slot1 full", {31'b0, hw_rd_valid}, 32'h1);
    sw_read_lit("slot1 word0 rewritten", 10'h080, 32'h2000_0000);

    // Write to a full slot.
    sw_write(10'h000, 32'hBAD0_BAD0);
    sw_read_lit("full slot write dropped", 10'h000, 32'h1000_0000);
    sw_read_lit("status err set", STATUS_ADDR, 32'h8000_0003);
    sw_write(STATUS_ADDR, 32'h8000_0000);
    sw_read_lit("status err cleared", STATUS_ADDR, 32'h0000_0003);

    // HW result into slot 2.
    hw_result(2'd2, {32{32'hA5A5_A5A5}});
    check("hw_wr_done pulse", {31'b0, hw_wr_done}, 32'h1);
    tick();
    check("hw_wr_done one cycle", {31'b0, hw_wr_done}, 32'h0);
    sw_read_lit("status result2", STATUS_ADDR, 32'h0000_0043);
    sw_read_lit("slot2 word0", 10'h100, 32'hA5A5_A5A5);

    // Same-slot collision: HW wins, err set.
    sw_addr = 10'h100; sw_wdata = 32'hDEAD_BEEF; sw_we = 1'b1;
    hw_result(2'd2, {32{32'h5A5A_5A5A}});
    sw_we = 1'b0;
    sw_read_lit("collision hw wins", 10'h100, 32'h5A5A_5A5A);
    sw_read_lit("collision err", STATUS_ADDR, 32'h8000_0043);

    // W1C of result in the same cycle as a new result: set wins.
    sw_addr = STATUS_ADDR; sw_wdata = 32'h8000_0040; sw_we = 1'b1;
    hw_result(2'd2, {32{32'h0F0F_0F0F}});
    sw_we = 1'b0;
    sw_read_lit("result set wins", STATUS_ADDR, 32'h0000_0043);
    sw_write(STATUS_ADDR, 32'h0000_0040);
    sw_read_lit("result w1c", STATUS_ADDR, 32'h0000_0003);

    // Different-slot collision: both complete.
    sw_addr = 10'h180; sw_wdata = 32'h3333_3333; sw_we = 1'b1;
    hw_result(2'd2, {32{32'hC3C3_C3C3}});
    sw_we = 1'b0;
    sw_read_lit("concurrent slot3 write", 10'h180, 32'h3333_3333);
    sw_read_lit("concurrent slot2 data", 10'h104, 32'hC3C3_C3C3);
    sw_read_lit("concurrent no err", STATUS_ADDR, 32'h0000_0043);

    // Reset with slot 3 half filled.
    for (int i = 1; i < 16; i++) sw_write(AW'(32'h180 + i * 4), 32'h3300_0000 + 32'(i));
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    sw_read_lit("status after mid reset", STATUS_ADDR, 32'h0);
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) sw_read_lit("slot3 needs full refill", STATUS_ADDR, 32'h0);
      sw_write(AW'(32'h180 + i * 4), 32'h3000_0000 + 32'(i));
    end
    sw_read_lit("slot3 full", STATUS_ADDR, 32'h0000_0008);

    // Consume slot 3.
    hw_rd_slot = 2'd3; hw_rd_ready = 1'b1;
    tick();
    hw_rd_ready = 1'b0;
    check("consume clears full", {31'b0, hw_rd_valid}, 32'h0);
    sw_read_lit("consume keeps data", 10'h180, 32'h3000_0000);

    // Unmapped addresses.
    sw_write(10'h300, 32'hFFFF_FFFF);
    sw_read_lit("unmapped read", 10'h204, 32'h0);
    sw_read_lit("unmapped write ignored", STATUS_ADDR, 32'h0);

    // Randomized phase.
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 80) sw_addr = AW'($urandom_range(0, NS * W - 1) * 4);
      else if (r < 90) sw_addr = STATUS_ADDR;
      else sw_addr = AW'($urandom_range(NS * W + 1, 255) * 4);
      sw_wdata    = $urandom;
      sw_we       = ($urandom_range(0, 1) == 1);
      sw_re       = ($urandom_range(0, 2) == 0);
      hw_rd_slot  = 2'($urandom_range(0, 3));
      hw_rd_ready = ($urandom_range(0, 7) == 0);
      hw_wr_slot  = 2'($urandom_range(0, 3));
      hw_wr_valid = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < W; i++) hw_wr_data[i*32 +: 32] = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        resetn = 1'b0; sw_we = 1'b0; hw_wr_valid = 1'b0;
      end else begin
        resetn = 1'b1;
      end
      tick();
    end
    resetn = 1'b1; sw_we = 1'b0; sw_re = 1'b0; hw_wr_valid = 1'b0; hw_rd_ready = 1'b0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
